// File: rtl/sdram_pkg.sv
// Shared constants and types for the 4-port SDRAM controller:
// SDRAM command codes, arbiter state encoding and idle bus values.
package sdram_pkg;

    localparam int PORT_NUM     = 4;
    localparam int SDRAM_BA_W   = 2;
    localparam int SDRAM_ADDR_W = 13;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_NOP      = 4'b0111,
        CMD_P_CHARGE = 4'b0010,
        CMD_A_REF    = 4'b0001,
        CMD_ACTIVE   = 4'b0011,
        CMD_WRITE    = 4'b0100,
        CMD_READ     = 4'b0101
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    typedef logic [1:0] port_idx_t;

    // Bus values driven while no engine owns the SDRAM pins
    localparam logic [SDRAM_BA_W-1:0]   IDLE_BA   = '1;
    localparam logic [SDRAM_ADDR_W-1:0] IDLE_ADDR = '1;

    function automatic logic [PORT_NUM-1:0] idx_to_onehot(input port_idx_t idx);
        return PORT_NUM'(1) << idx;
    endfunction

endpackage

// File: rtl/sdram_port_arbit_if.sv
// User-port request/grant handshake between the requesters (master)
// and the SDRAM command-bus arbiter (slave).
interface sdram_port_arbit_if;
    import sdram_pkg::*;

    logic [PORT_NUM-1:0] port_req;  // per-port access request (level)
    logic [PORT_NUM-1:0] port_we;   // 1 = write, 0 = read
    logic [PORT_NUM-1:0] port_gnt;  // one-hot grant, held for the access

    modport master (
        output port_req,
        output port_we,
        input  port_gnt
    );

    modport slave (
        input  port_req,
        input  port_we,
        output port_gnt
    );

endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational port picker for the SDRAM arbiter.
// Default: round-robin, search starts at last+1 and wraps 3 -> 0.
// ARB_FIXED_PRIO_EN defined: fixed priority, port 0 highest, last ignored.
module sdram_rr_pick
    import sdram_pkg::*;
(
    input  logic [PORT_NUM-1:0] req,
    input  port_idx_t           last,
    output logic [PORT_NUM-1:0] pick,
    output port_idx_t           idx,
    output logic                valid
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;
`endif

    // Select the winning requester and its one-hot form
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
`ifdef ARB_FIXED_PRIO_EN
        // Scan low priority first so the lowest index wins
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            if (req[k]) begin
                valid = 1'b1;
                idx   = port_idx_t'(k);
            end
        end
`else
        // Offsets 1..4 from the last grant; the 2-bit sum wraps naturally
        for (int k = 1; k <= PORT_NUM; k++) begin
            if (!valid && req[last + port_idx_t'(k)]) begin
                valid = 1'b1;
                idx   = last + port_idx_t'(k);
            end
        end
`endif
        pick = valid ? idx_to_onehot(idx) : '0;
    end

endmodule

// File: rtl/sdram_port_arbit.sv
// Single owner of the SDRAM command bus: waits for init, then arbitrates
// between auto-refresh (always first) and the 4 user ports, sequences the
// granted port through the write or read engine and muxes engine commands
// onto the SDRAM pins.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed port priority
// instead of round-robin (handled in sdram_rr_pick).
module sdram_port_arbit
    import sdram_pkg::*;
#(
    parameter int BA_W   = SDRAM_BA_W,
    parameter int ADDR_W = SDRAM_ADDR_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,

    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              aref_en,

    sdram_port_arbit_if.slave arb,

    output logic              wr_en,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,

    output logic              rd_en,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr
);

    arb_state_e          state;
    arb_state_e          state_next;
    logic [PORT_NUM-1:0] gnt_q;
    port_idx_t           last_gnt;
    logic [PORT_NUM-1:0] pick_onehot;
    port_idx_t           pick_idx;
    logic                pick_valid;
    logic                grant_load;

    sdram_rr_pick u_pick (
        .req   (arb.port_req),
        .last  (last_gnt),
        .pick  (pick_onehot),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A port is granted only when refresh is not asking in the same cycle
    assign grant_load   = (state == ST_ARBIT) && !aref_req && pick_valid;
    assign arb.port_gnt = gnt_q;

    // State register
    // NOTE: clocked blocks use <= so every register sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_INIT;
        else         state <= state_next;
    end

    // Next-state logic; end pulses only matter in their own state
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (init_end) state_next = ST_ARBIT;
            ST_ARBIT: begin
                if (aref_req)        state_next = ST_AREF;
                else if (pick_valid) state_next = arb.port_we[pick_idx] ? ST_WRITE : ST_READ;
            end
            ST_AREF:  if (aref_end) state_next = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_next = ST_ARBIT;
            ST_READ:  if (rd_end)   state_next = ST_ARBIT;
            default:  state_next = ST_INIT;
        endcase
    end

    // Grant register: loaded on leaving ARBIT, cleared on returning to it
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt_q    <= '0;
            last_gnt <= port_idx_t'(PORT_NUM - 1);
        end else if (grant_load) begin
            gnt_q    <= pick_onehot;
            last_gnt <= pick_idx;
        end else if (state != ST_ARBIT && state_next == ST_ARBIT) begin
            gnt_q    <= '0;
        end
    end

    // Engine enables (masked by their end pulse) and SDRAM pin mux
    always_comb begin
        aref_en    = (state == ST_AREF)  && !aref_end;
        wr_en      = (state == ST_WRITE) && !wr_end;
        rd_en      = (state == ST_READ)  && !rd_end;
        sdram_cmd  = CMD_NOP;
        sdram_ba   = IDLE_BA;
        sdram_addr = IDLE_ADDR;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_port_arbit.sv
// Directed bench for sdram_port_arbit: expected grants are queued when
// requests are driven and popped when the arbiter issues a grant.
module tb_sdram_port_arbit;
    import sdram_pkg::*;

    localparam int BA_W   = 2;
    localparam int ADDR_W = 13;

    typedef struct {
        int unsigned idx;
        bit          we;
    } exp_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              aref_req, aref_end, aref_en;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              wr_en, wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en, rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    sdram_port_arbit_if arb_if ();

    sdram_port_arbit dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .init_end   (init_end),
        .init_cmd   (init_cmd),
        .init_ba    (init_ba),
        .init_addr  (init_addr),
        .aref_req   (aref_req),
        .aref_end   (aref_end),
        .aref_cmd   (aref_cmd),
        .aref_ba    (aref_ba),
        .aref_addr  (aref_addr),
        .aref_en    (aref_en),
        .arb        (arb_if),
        .wr_en      (wr_en),
        .wr_end     (wr_end),
        .wr_cmd     (wr_cmd),
        .wr_ba      (wr_ba),
        .wr_addr    (wr_addr),
        .rd_en      (rd_en),
        .rd_end     (rd_end),
        .rd_cmd     (rd_cmd),
        .rd_ba      (rd_ba),
        .rd_addr    (rd_addr),
        .sdram_cmd  (sdram_cmd),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int unsigned idx, input bit we);
        exp_t e;
        e.idx = idx;
        e.we  = we;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},  32'(arb_if.port_gnt), 32'(0));
        check({tag, "_cmd"},  32'(sdram_cmd), 32'(CMD_NOP));
        check({tag, "_ba"},   32'(sdram_ba), 32'(2'b11));
        check({tag, "_addr"}, 32'(sdram_addr), 32'(13'h1fff));
        check({tag, "_en"},   32'({aref_en, wr_en, rd_en}), 32'(0));
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            #1;
            n++;
        end while (arb_if.port_gnt == '0 && n < 20);
    endtask

    // Serve one access: engine end pulse 8 cycles after its enable rose
    task automatic serve(input logic [3:0] req_after, input bit aref_mid);
        int   n;
        exp_t e;
        wait_grant(n);
        check("grant_latency", 32'(n), 32'(1));
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check("gnt",    32'(arb_if.port_gnt), 32'(4'b0001 << e.idx));
        check("wr_en",  32'(wr_en), 32'(e.we));
        check("rd_en",  32'(rd_en), 32'(!e.we));
        check("aref_en_busy", 32'(aref_en), 32'(0));
        check("eng_cmd",  32'(sdram_cmd),  32'(e.we ? wr_cmd : rd_cmd));
        check("eng_addr", 32'(sdram_addr), 32'(e.we ? wr_addr : rd_addr));
        arb_if.port_req = req_after;
        for (int k = 1; k <= 7; k++) begin
            @(negedge sys_clk);
            if (k == 2) begin
                aref_end = 1'b1;
                if (e.we) rd_end = 1'b1;
                else      wr_end = 1'b1;
            end
            if (k == 3) begin
                aref_end = 1'b0;
                rd_end   = 1'b0;
                wr_end   = 1'b0;
                if (aref_mid) aref_req = 1'b1;
            end
            #1;
            if (k == 2) check("stray_end_ignored", 32'(e.we ? wr_en : rd_en), 32'(1));
            if (k == 7) begin
                check("hold_en",  32'(e.we ? wr_en : rd_en), 32'(1));
                check("hold_gnt", 32'(arb_if.port_gnt), 32'(4'b0001 << e.idx));
                check("hold_no_aref", 32'(aref_en), 32'(0));
            end
        end
        @(negedge sys_clk);
        if (e.we) wr_end = 1'b1;
        else      rd_end = 1'b1;
        #1;
        check("end_masks_en", 32'(e.we ? wr_en : rd_en), 32'(0));
        check("end_gnt_held", 32'(arb_if.port_gnt), 32'(4'b0001 << e.idx));
        @(negedge sys_clk);
        wr_end = 1'b0;
        rd_end = 1'b0;
        #1;
        check_idle("post_access");
    endtask

    // Refresh entered at the next edge (aref_req already high), ended after 3 cycles
    task automatic refresh_cycle();
        @(negedge sys_clk);
        #1;
        check("aref_en",  32'(aref_en), 32'(1));
        check("aref_cmd", 32'(sdram_cmd), 32'(aref_cmd));
        check("aref_ba",  32'(sdram_ba), 32'(aref_ba));
        check("aref_gnt", 32'(arb_if.port_gnt), 32'(0));
        check("aref_no_eng", 32'({wr_en, rd_en}), 32'(0));
        aref_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        @(negedge sys_clk);
        aref_end = 1'b1;
        #1;
        check("aref_end_masks", 32'(aref_en), 32'(0));
        @(negedge sys_clk);
        aref_end = 1'b0;
        #1;
        check_idle("post_aref");
    endtask

    initial begin
        int   n;
        exp_t e;
        sys_rst   = 1'b1;
        init_end  = 1'b0;
        init_cmd  = CMD_P_CHARGE;
        init_ba   = 2'd0;
        init_addr = 13'h0400;
        aref_req  = 1'b0;
        aref_end  = 1'b0;
        aref_cmd  = CMD_A_REF;
        aref_ba   = 2'd1;
        aref_addr = 13'h0aaa;
        wr_end    = 1'b0;
        wr_cmd    = CMD_WRITE;
        wr_ba     = 2'd2;
        wr_addr   = 13'h0123;
        rd_end    = 1'b0;
        rd_cmd    = CMD_READ;
        rd_ba     = 2'd0;
        rd_addr   = 13'h0456;
        arb_if.port_req = 4'b0000;
        arb_if.port_we  = 4'b0000;

        // Reset state
        repeat (2) @(negedge sys_clk);
        #1;
        check("rst_gnt",  32'(arb_if.port_gnt), 32'(0));
        check("rst_en",   32'({aref_en, wr_en, rd_en}), 32'(0));
        check("rst_cmd",  32'(sdram_cmd), 32'(init_cmd));
        check("rst_addr", 32'(sdram_addr), 32'(init_addr));
        sys_rst = 1'b0;

        // 1: INIT passes init_* through until init_end
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            init_cmd = 4'($urandom_range(0, 15));
            #1;
            check("init_cmd", 32'(sdram_cmd), 32'(init_cmd));
            check("init_gnt", 32'(arb_if.port_gnt), 32'(0));
        end
        init_cmd = CMD_P_CHARGE;
        @(negedge sys_clk);
        init_end = 1'b1;
        @(negedge sys_clk);
        #1;
        check_idle("arbit_entry");
        init_end = 1'b0;
        @(negedge sys_clk);
        #1;
        check("init_end_fall_ignored", 32'(sdram_cmd), 32'(CMD_NOP));

        // 2: all ports requesting, round-robin 0,1,2,3,0; last access drops its request
        arb_if.port_req = 4'b1111;
        arb_if.port_we  = 4'b0101;
        push_exp(0, 1'b1);
        push_exp(1, 1'b0);
        push_exp(2, 1'b1);
        push_exp(3, 1'b0);
        push_exp(0, 1'b1);
        repeat (4) serve(4'b1111, 1'b0);
        serve(4'b0000, 1'b0);

        // 3: refresh and port 1 in the same ARBIT cycle -> refresh first
        aref_req        = 1'b1;
        arb_if.port_req = 4'b0010;
        refresh_cycle();
        push_exp(1, 1'b0);
        serve(4'b0000, 1'b0);

        // 4: refresh raised mid-write on port 2 waits for wr_end and one ARBIT cycle
        arb_if.port_req = 4'b0100;
        push_exp(2, 1'b1);
        serve(4'b0000, 1'b1);
        refresh_cycle();

        // 5: reset during a read on port 3
        arb_if.port_req = 4'b1000;
        push_exp(3, 1'b0);
        wait_grant(n);
        check("rd_grant_latency", 32'(n), 32'(1));
        e = sb_q.pop_front();
        check("rd_gnt", 32'(arb_if.port_gnt), 32'(4'b0001 << e.idx));
        check("rd_en_on", 32'(rd_en), 32'(1));
        arb_if.port_req = 4'b0000;
        repeat (2) @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        #1;
        check("midrst_gnt", 32'(arb_if.port_gnt), 32'(0));
        check("midrst_en",  32'({aref_en, wr_en, rd_en}), 32'(0));
        check("midrst_cmd", 32'(sdram_cmd), 32'(init_cmd));
        sys_rst = 1'b0;
        @(negedge sys_clk);
        #1;
        check("midrst_hold_init", 32'(sdram_cmd), 32'(init_cmd));
        init_end = 1'b1;
        @(negedge sys_clk);
        #1;
        check_idle("rearbit");
        init_end = 1'b0;

        // 6: ports 0 and 3 held; first grant is port 0 after reset
        arb_if.port_req = 4'b1001;
        arb_if.port_we  = 4'b1001;
`ifdef ARB_FIXED_PRIO_EN
        push_exp(0, 1'b1);
        push_exp(0, 1'b1);
        push_exp(0, 1'b1);
`else
        push_exp(0, 1'b1);
        push_exp(3, 1'b1);
        push_exp(0, 1'b1);
`endif
        serve(4'b1001, 1'b0);
        serve(4'b1001, 1'b0);
        serve(4'b0000, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
